// File: rtl/fetch_stage_pkg.sv
// Shared CPU constants for fetch, decode and control: opcode field layout,
// halt opcode, bubble word and the fetch FSM state encoding.
package fetch_stage_pkg;

    localparam int unsigned CPU_INSTR_W = 16;
    localparam int unsigned CPU_OPC_W   = 4;
    localparam int unsigned CPU_OPC_LSB = CPU_INSTR_W - CPU_OPC_W;

    localparam logic [CPU_OPC_W-1:0]   CPU_HALT_OPC  = 4'hF;
    localparam logic [CPU_INSTR_W-1:0] CPU_NOP_INSTR = 16'h0000;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if_id_buffer.sv
// IF/ID pipeline register: captures instruction, pc_next and valid on load,
// holds otherwise, and inserts a NOP bubble on request.
module if_id_buffer
    import fetch_stage_pkg::*;
#(
    parameter int unsigned             ADDR_W    = 16,
    parameter int unsigned             INSTR_W   = 16,
    parameter logic [INSTR_W-1:0]      NOP_INSTR = CPU_NOP_INSTR
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               load,
    input  logic               bubble,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic [ADDR_W-1:0]  pc_next_in,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  pc_next,
    output logic               valid
);

    always_ff @(posedge clock) begin
        if (reset) begin
            instr   <= NOP_INSTR;
            pc_next <= '0;
            valid   <= 1'b0;
        end else if (bubble) begin
            instr   <= NOP_INSTR;
            pc_next <= '0;
            valid   <= 1'b0;
        end else if (load) begin
            instr   <= instr_in;
            pc_next <= pc_next_in;
            valid   <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, +PC_STEP sequencing, branch redirect, stall,
// halt detection (RUN/HALTED FSM), saturating fetch counter and IF/ID register.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int unsigned          ADDR_W     = 16,
    parameter int unsigned          INSTR_W    = 16,
    parameter int unsigned          PC_STEP    = 2,
    parameter logic [ADDR_W-1:0]    RESET_ADDR = '0,
    parameter int unsigned          OPC_W      = 4,
    parameter logic [OPC_W-1:0]     HALT_OPC   = CPU_HALT_OPC,
    parameter logic [INSTR_W-1:0]   NOP_INSTR  = CPU_NOP_INSTR,
    parameter int unsigned          CNT_W      = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [ADDR_W-1:0]  ifid_pc_next,
    output logic               ifid_valid,
    output logic               halted,
    output logic [CNT_W-1:0]   fetch_count
);

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

    fetch_state_t       state;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  pc_plus;
    logic [OPC_W-1:0]   opcode;
    logic               is_halt;
    logic               buf_load;
    logic               buf_bubble;

    assign imem_addr = pc;
    assign pc_plus   = pc + STEP;
    assign opcode    = imem_rdata[INSTR_W-1 -: OPC_W];
    assign is_halt   = (opcode == HALT_OPC);
    assign halted    = (state == HALTED);

    // Redirect and HALTED both force a bubble, and both override stall.
    always_comb begin
        buf_load   = 1'b0;
        buf_bubble = 1'b0;
        if (branch_taken || state == HALTED) begin
            buf_bubble = 1'b1;
        end else if (!stall) begin
            buf_load = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc          <= RESET_ADDR;
            state       <= RUN;
            fetch_count <= '0;
        end else if (branch_taken) begin
            pc    <= branch_target;
            state <= RUN;
        end else if (state == RUN && !stall) begin
            if (fetch_count != '1) begin
                fetch_count <= fetch_count + CNT_W'(1);
            end
            // The halt word itself is captured, but pc stays on it.
            if (is_halt) begin
                state <= HALTED;
            end else begin
                pc <= pc_plus;
            end
        end
    end

    if_id_buffer #(
        .ADDR_W    (ADDR_W),
        .INSTR_W   (INSTR_W),
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clock      (clock),
        .reset      (reset),
        .load       (buf_load),
        .bubble     (buf_bubble),
        .instr_in   (imem_rdata),
        .pc_next_in (pc_plus),
        .instr      (ifid_instr),
        .pc_next    (ifid_pc_next),
        .valid      (ifid_valid)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed table-driven bench for fetch_stage plus a narrow-counter
// saturation sequence on a second instance.
module tb_fetch_stage;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        br;
        logic [15:0] target;
        logic [15:0] rdata;
        logic [15:0] e_addr;
        logic [15:0] e_instr;
        logic        chk_pcn;
        logic [15:0] e_pcn;
        logic        e_valid;
        logic        e_halted;
        logic [15:0] e_count;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset, stall, branch_taken;
    logic [15:0] branch_target, imem_addr, imem_rdata;
    logic [15:0] ifid_instr, ifid_pc_next, fetch_count;
    logic        ifid_valid, halted;

    logic        s_reset, s_stall, s_branch_taken;
    logic [15:0] s_branch_target, s_imem_addr, s_imem_rdata;
    logic [15:0] s_ifid_instr, s_ifid_pc_next;
    logic        s_ifid_valid, s_halted;
    logic [1:0]  s_fetch_count;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;
    vec_t        vecs[$];

    always #5 clock = ~clock;

    fetch_stage u_dut (
        .clock         (clock),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .ifid_instr    (ifid_instr),
        .ifid_pc_next  (ifid_pc_next),
        .ifid_valid    (ifid_valid),
        .halted        (halted),
        .fetch_count   (fetch_count)
    );

    fetch_stage #(.CNT_W(2)) u_sat (
        .clock         (clock),
        .reset         (s_reset),
        .stall         (s_stall),
        .branch_taken  (s_branch_taken),
        .branch_target (s_branch_target),
        .imem_addr     (s_imem_addr),
        .imem_rdata    (s_imem_rdata),
        .ifid_instr    (s_ifid_instr),
        .ifid_pc_next  (s_ifid_pc_next),
        .ifid_valid    (s_ifid_valid),
        .halted        (s_halted),
        .fetch_count   (s_fetch_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic add(input logic rst, input logic stl, input logic br, input logic [15:0] tgt,
                       input logic [15:0] rd, input logic [15:0] ea, input logic [15:0] ei,
                       input logic cp, input logic [15:0] ep, input logic ev, input logic eh,
                       input logic [15:0] ec);
        vec_t v;
        v.rst = rst; v.stall = stl; v.br = br; v.target = tgt; v.rdata = rd;
        v.e_addr = ea; v.e_instr = ei; v.chk_pcn = cp; v.e_pcn = ep;
        v.e_valid = ev; v.e_halted = eh; v.e_count = ec;
        vecs.push_back(v);
    endtask

    initial begin
        logic [1:0] sat_exp[5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

        //   rst stl br target    rdata      addr       instr     cp pcn       v  h  count
        add(1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1, 16'h0000, 0, 0, 16'd0);
        add(0, 0, 0, 16'h0000, 16'h1111, 16'h0002, 16'h1111, 1, 16'h0002, 1, 0, 16'd1);
        add(0, 0, 0, 16'h0000, 16'h2222, 16'h0004, 16'h2222, 1, 16'h0004, 1, 0, 16'd2);
        add(0, 0, 0, 16'h0000, 16'h3333, 16'h0006, 16'h3333, 1, 16'h0006, 1, 0, 16'd3);
        add(0, 0, 0, 16'h0000, 16'h4444, 16'h0008, 16'h4444, 1, 16'h0008, 1, 0, 16'd4);
        add(0, 1, 0, 16'h0000, 16'h5555, 16'h0008, 16'h4444, 1, 16'h0008, 1, 0, 16'd4);
        add(0, 1, 0, 16'h0000, 16'h5555, 16'h0008, 16'h4444, 1, 16'h0008, 1, 0, 16'd4);
        add(0, 1, 0, 16'h0000, 16'hF000, 16'h0008, 16'h4444, 1, 16'h0008, 1, 0, 16'd4);
        add(0, 0, 0, 16'h0000, 16'h5555, 16'h000A, 16'h5555, 1, 16'h000A, 1, 0, 16'd5);
        // redirect beats stall and a halt word on the bus
        add(0, 1, 1, 16'h0040, 16'hF000, 16'h0040, 16'h0000, 0, 16'h0000, 0, 0, 16'd5);
        add(0, 0, 0, 16'h0000, 16'h6666, 16'h0042, 16'h6666, 1, 16'h0042, 1, 0, 16'd6);
        add(0, 0, 1, 16'h0010, 16'h6666, 16'h0010, 16'h0000, 0, 16'h0000, 0, 0, 16'd6);
        add(0, 0, 0, 16'h0000, 16'hF000, 16'h0010, 16'hF000, 1, 16'h0012, 1, 1, 16'd7);
        add(0, 0, 0, 16'h0000, 16'hF000, 16'h0010, 16'h0000, 0, 16'h0000, 0, 1, 16'd7);
        add(0, 1, 0, 16'h0000, 16'h7777, 16'h0010, 16'h0000, 0, 16'h0000, 0, 1, 16'd7);
        add(0, 0, 1, 16'h0020, 16'h7777, 16'h0020, 16'h0000, 0, 16'h0000, 0, 0, 16'd7);
        add(0, 0, 0, 16'h0000, 16'h8888, 16'h0022, 16'h8888, 1, 16'h0022, 1, 0, 16'd8);
        add(0, 0, 1, 16'hFFFE, 16'h8888, 16'hFFFE, 16'h0000, 0, 16'h0000, 0, 0, 16'd8);
        add(0, 0, 0, 16'h0000, 16'h9999, 16'h0000, 16'h9999, 1, 16'h0000, 1, 0, 16'd9);
        add(0, 0, 1, 16'h0030, 16'h9999, 16'h0030, 16'h0000, 0, 16'h0000, 0, 0, 16'd9);
        add(0, 0, 0, 16'h0000, 16'hF123, 16'h0030, 16'hF123, 1, 16'h0032, 1, 1, 16'd10);
        // reset while HALTED, also beating a redirect
        add(1, 0, 1, 16'h0050, 16'hF000, 16'h0000, 16'h0000, 1, 16'h0000, 0, 0, 16'd0);
        add(0, 0, 0, 16'h0000, 16'h1234, 16'h0002, 16'h1234, 1, 16'h0002, 1, 0, 16'd1);
        add(0, 1, 0, 16'h0000, 16'h5678, 16'h0002, 16'h1234, 1, 16'h0002, 1, 0, 16'd1);
        // reset mid-stall
        add(1, 1, 0, 16'h0000, 16'h5678, 16'h0000, 16'h0000, 1, 16'h0000, 0, 0, 16'd0);

        s_reset = 1'b1; s_stall = 1'b0; s_branch_taken = 1'b0;
        s_branch_target = 16'h0000; s_imem_rdata = 16'h1111;

        foreach (vecs[i]) begin
            reset         = vecs[i].rst;
            stall         = vecs[i].stall;
            branch_taken  = vecs[i].br;
            branch_target = vecs[i].target;
            imem_rdata    = vecs[i].rdata;
            @(posedge clock);
            #1;
            check($sformatf("v%0d_addr", i),   32'(imem_addr),   32'(vecs[i].e_addr));
            check($sformatf("v%0d_instr", i),  32'(ifid_instr),  32'(vecs[i].e_instr));
            if (vecs[i].chk_pcn)
                check($sformatf("v%0d_pcnext", i), 32'(ifid_pc_next), 32'(vecs[i].e_pcn));
            check($sformatf("v%0d_valid", i),  32'(ifid_valid),  32'(vecs[i].e_valid));
            check($sformatf("v%0d_halted", i), 32'(halted),      32'(vecs[i].e_halted));
            check($sformatf("v%0d_count", i),  32'(fetch_count), 32'(vecs[i].e_count));
        end

        // Narrow counter: five valid fetches saturate a 2-bit count at 3.
        @(posedge clock);
        #1;
        check("sat_reset_count", 32'(s_fetch_count), 32'd0);
        s_reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clock);
            #1;
            check($sformatf("sat_count_%0d", k), 32'(s_fetch_count), 32'(sat_exp[k]));
        end
        check("sat_addr", 32'(s_imem_addr), 32'h000A);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
